// File: rtl/reg_context_engine_if.sv
// Register-file and memory channels of the context engine.
// master = engine side, slave = register file / memory side.
interface reg_context_engine_if #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter int ADDRESS_BITS   = 20
);
    logic [REG_SEL_BITS-1:0]   rf_read_sel;
    logic [REG_DATA_WIDTH-1:0] rf_read_data;
    logic                      rf_wEn;
    logic [REG_SEL_BITS-1:0]   rf_write_sel;
    logic [REG_DATA_WIDTH-1:0] rf_write_data;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic                      mem_req_write;
    logic [ADDRESS_BITS-1:0]   mem_req_addr;
    logic [REG_DATA_WIDTH-1:0] mem_req_data;
    logic                      mem_rsp_valid;
    logic [REG_DATA_WIDTH-1:0] mem_rsp_data;

    modport master (
        output rf_read_sel, rf_wEn, rf_write_sel, rf_write_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
        input  rf_read_data, mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    modport slave (
        input  rf_read_sel, rf_wEn, rf_write_sel, rf_write_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_data,
        output rf_read_data, mem_req_ready, mem_rsp_valid, mem_rsp_data
    );
endinterface

// File: rtl/reg_context_engine.sv
// Saves registers 1..N-1 to a memory context area or restores them from it.
// All outputs are decoded from registered state only.
module reg_context_engine #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_SEL_BITS   = 5,
    parameter int ADDRESS_BITS   = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    save_req,
    input  logic                    restore_req,
    input  logic [ADDRESS_BITS-1:0] base_addr,
    output logic                    busy,
    output logic                    done,
    reg_context_engine_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE_RD,
        SAVE_REQ,
        RST_REQ,
        RST_WAIT,
        RST_WR,
        DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [REG_SEL_BITS-1:0]   idx_q, idx_d;
    logic [REG_DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDRESS_BITS-1:0]   base_q, base_d;

    logic [ADDRESS_BITS-1:0] offset_w;
    logic [ADDRESS_BITS-1:0] addr_w;
    logic                    last_w;

    // Word offset of the current register; the sum wraps in the address space.
    assign offset_w = ADDRESS_BITS'({idx_q, 2'b00});
    assign addr_w   = base_q + offset_w;
    assign last_w   = &idx_q;

    // Next-state sequencing; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        base_d  = base_q;
        unique case (state_q)
            IDLE: begin
                if (save_req) begin
                    base_d  = base_addr;
                    idx_d   = REG_SEL_BITS'(1);
                    state_d = SAVE_RD;
                end else if (restore_req) begin
                    base_d  = base_addr;
                    idx_d   = REG_SEL_BITS'(1);
                    state_d = RST_REQ;
                end
            end
            SAVE_RD: begin
                data_d  = bus.rf_read_data;
                state_d = SAVE_REQ;
            end
            SAVE_REQ: begin
                if (bus.mem_req_ready) begin
                    if (last_w) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SAVE_RD;
                    end
                end
            end
            RST_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = RST_WAIT;
                end
            end
            RST_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    data_d  = bus.mem_rsp_data;
                    state_d = RST_WR;
                end
            end
            RST_WR: begin
                if (last_w) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RST_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            base_q  <= base_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign bus.rf_read_sel   = idx_q;
    assign bus.rf_wEn        = (state_q == RST_WR);
    assign bus.rf_write_sel  = bus.rf_wEn ? idx_q : '0;
    assign bus.rf_write_data = bus.rf_wEn ? data_q : '0;

    assign bus.mem_req_valid = (state_q == SAVE_REQ) || (state_q == RST_REQ);
    assign bus.mem_req_write = (state_q == SAVE_REQ);
    assign bus.mem_req_addr  = bus.mem_req_valid ? addr_w : '0;
    assign bus.mem_req_data  = bus.mem_req_write ? data_q : '0;

endmodule

// File: tb/tb_reg_context_engine.sv
// Scoreboard bench for reg_context_engine: expected memory requests,
// register writes and done cycles are queued and checked by a monitor.
module tb_reg_context_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        save_req;
    logic        restore_req;
    logic [19:0] base_addr;
    logic        busy;
    logic        done;

    reg_context_engine_if #(
        .REG_DATA_WIDTH(32),
        .REG_SEL_BITS(5),
        .ADDRESS_BITS(20)
    ) bus ();

    reg_context_engine #(
        .REG_DATA_WIDTH(32),
        .REG_SEL_BITS(5),
        .ADDRESS_BITS(20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .save_req(save_req),
        .restore_req(restore_req),
        .base_addr(base_addr),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [31:0] data;
    } mreq_t;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
    } rfw_t;

    mreq_t mem_q[$];
    rfw_t  rf_q[$];
    int    done_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic busy_next_chk = 1'b0;

    logic [31:0] regs [32];
    logic [31:0] pre [32];
    logic        pre_go = 1'b0;
    logic [31:0] mem [int unsigned];

    logic [19:0] skip_addr = 20'hFFFFF;
    logic [19:0] stall_addr = 20'h0;
    int          stall_left = 0;
    logic        force_rsp = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_data = 32'h0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Register file model: combinational read, write on rf_wEn.
    assign bus.rf_read_data = regs[bus.rf_read_sel];

    always @(posedge clock) begin
        if (pre_go) begin
            for (int k = 0; k < 32; k++) regs[k] <= pre[k];
        end else if (bus.rf_wEn) begin
            regs[bus.rf_write_sel] <= bus.rf_write_data;
        end
    end

    // Memory model: ready (with optional stall), read response next cycle.
    always @(negedge clock) begin
        bus.mem_rsp_valid = force_rsp | pend;
        bus.mem_rsp_data  = force_rsp ? 32'h1234 : pend_data;
        if (bus.mem_req_valid && bus.mem_req_addr == stall_addr &&
            stall_left > 0) begin
            bus.mem_req_ready = 1'b0;
            stall_left--;
            chk("stall_write", bus.mem_req_write, 1);
            chk("stall_data", bus.mem_req_data, 32'hA7);
            chk("stall_sel", bus.rf_read_sel, 7);
        end else begin
            bus.mem_req_ready = 1'b1;
        end
        pend = bus.mem_req_valid && bus.mem_req_ready &&
               !bus.mem_req_write && bus.mem_req_addr != skip_addr;
        pend_data = mem.exists(32'(bus.mem_req_addr)) ?
                    mem[32'(bus.mem_req_addr)] : 32'hDEADBEEF;
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin
        mreq_t m;
        rfw_t  r;
        int    d;
        #1;
        if (!reset) begin
            if (busy_next_chk) begin
                chk("busy_after_done", busy, 0);
                busy_next_chk = 1'b0;
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_memreq addr=%0h", bus.mem_req_addr);
                end else begin
                    m = mem_q.pop_front();
                    chk("req_write", bus.mem_req_write, m.wr);
                    chk("req_addr", bus.mem_req_addr, m.addr);
                    chk("req_data", bus.mem_req_data, m.data);
                end
            end
            if (bus.rf_wEn) begin
                if (rf_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rf_write sel=%0d", bus.rf_write_sel);
                end else begin
                    r = rf_q.pop_front();
                    chk("rf_sel", bus.rf_write_sel, r.sel);
                    chk("rf_data", bus.rf_write_data, r.data);
                end
            end
            if (done) begin
                done_cnt++;
                busy_next_chk = 1'b1;
                chk("busy_at_done", busy, 1);
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done cycle=%0d", cyc);
                end else begin
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #2;
    endtask

    task automatic preload(logic [31:0] base_val, logic [31:0] r0);
        for (int k = 0; k < 32; k++) pre[k] = base_val + k;
        pre[0] = r0;
        pre_go = 1'b1;
        sync();
        pre_go = 1'b0;
    endtask

    task automatic run_wait(string name, int maxc);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < maxc) begin
            @(negedge clock);
            #2;
            k++;
        end
        chk({name, "_done_seen"}, done_cnt - n0, 1);
        repeat (3) @(negedge clock);
        #2;
        chk({name, "_memq_empty"}, mem_q.size(), 0);
        chk({name, "_rfq_empty"}, rf_q.size(), 0);
        chk({name, "_doneq_empty"}, done_q.size(), 0);
    endtask

    task automatic check_reset_outputs(string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_rf_wEn"}, bus.rf_wEn, 0);
        chk({name, "_rf_wsel"}, bus.rf_write_sel, 0);
        chk({name, "_rf_wdata"}, bus.rf_write_data, 0);
        chk({name, "_valid"}, bus.mem_req_valid, 0);
        chk({name, "_write"}, bus.mem_req_write, 0);
        chk({name, "_addr"}, bus.mem_req_addr, 0);
        chk({name, "_data"}, bus.mem_req_data, 0);
        chk({name, "_rsel"}, bus.rf_read_sel, 0);
    endtask

    task automatic push_save(logic [19:0] base, logic [31:0] val0);
        for (int k = 1; k < 32; k++)
            mem_q.push_back('{1'b1, 20'(32'(base) + 4 * k), val0 + 32'(k)});
    endtask

    initial begin
        int k;
        reset = 1'b1;
        save_req = 1'b0;
        restore_req = 1'b0;
        base_addr = 20'h0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        repeat (3) @(posedge clock);
        #2;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Plain save, ready always high.
        preload(32'hA0, 32'hA0);
        push_save(20'h01000, 32'hA0);
        done_q.push_back(cyc + 63);
        base_addr = 20'h01000;
        save_req = 1'b1;
        sync();
        save_req = 1'b0;
        base_addr = 20'h0ABCD;
        run_wait("save", 200);

        // Restore, response one cycle after acceptance.
        for (int i = 0; i < 32; i++) mem[32'h02000 + 4 * i] = 32'h5000 + i;
        preload(32'h0, 32'hDEAD);
        for (int i = 1; i < 32; i++) begin
            mem_q.push_back('{1'b0, 20'(32'h02000 + 4 * i), 32'h0});
            rf_q.push_back('{5'(i), 32'h5000 + i});
        end
        done_q.push_back(cyc + 94);
        base_addr = 20'h02000;
        restore_req = 1'b1;
        sync();
        restore_req = 1'b0;
        run_wait("restore", 300);
        chk("restore_reg0", regs[0], 32'hDEAD);
        chk("restore_reg31", regs[31], 32'h501F);

        // Save with three stall cycles at idx 7.
        preload(32'hA0, 32'hA0);
        stall_addr = 20'h0101C;
        stall_left = 3;
        push_save(20'h01000, 32'hA0);
        done_q.push_back(cyc + 66);
        base_addr = 20'h01000;
        save_req = 1'b1;
        sync();
        save_req = 1'b0;
        run_wait("stall", 200);
        chk("stall_consumed", stall_left, 0);

        // Save near the top of the address space wraps.
        push_save(20'hFFFF0, 32'hA0);
        done_q.push_back(cyc + 63);
        base_addr = 20'hFFFF0;
        save_req = 1'b1;
        sync();
        save_req = 1'b0;
        run_wait("wrap", 200);

        // Both requests: save wins; a restore pulse mid-save is ignored.
        push_save(20'h01000, 32'hA0);
        done_q.push_back(cyc + 63);
        base_addr = 20'h01000;
        save_req = 1'b1;
        restore_req = 1'b1;
        sync();
        save_req = 1'b0;
        restore_req = 1'b0;
        k = 0;
        while (!(bus.mem_req_valid && bus.mem_req_write &&
                 bus.mem_req_addr == 20'h01028) && k < 100) begin
            @(negedge clock);
            #2;
            k++;
        end
        chk("both_reach_idx10", bus.rf_read_sel, 10);
        restore_req = 1'b1;
        sync();
        restore_req = 1'b0;
        run_wait("both", 200);

        // Reset in RST_WAIT at idx 12; the late response must be ignored.
        skip_addr = 20'h02030;
        for (int i = 1; i <= 12; i++)
            mem_q.push_back('{1'b0, 20'(32'h02000 + 4 * i), 32'h0});
        for (int i = 1; i <= 11; i++)
            rf_q.push_back('{5'(i), 32'h5000 + i});
        base_addr = 20'h02000;
        restore_req = 1'b1;
        sync();
        restore_req = 1'b0;
        k = 0;
        while (!(bus.mem_req_valid && !bus.mem_req_write &&
                 bus.mem_req_addr == 20'h02030) && k < 200) begin
            @(negedge clock);
            #2;
            k++;
        end
        chk("abort_reach_idx12", bus.rf_read_sel, 12);
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        force_rsp = 1'b1;
        @(negedge clock);
        #2;
        force_rsp = 1'b0;
        chk("abort_rsp_driven", bus.mem_rsp_valid, 1);
        repeat (3) begin
            @(negedge clock);
            #2;
            check_reset_outputs("abort");
        end
        chk("abort_memq_empty", mem_q.size(), 0);
        chk("abort_rfq_empty", rf_q.size(), 0);
        chk("abort_no_done", done_cnt, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
